// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared state type and line/beat geometry for the cacheline adapter
package cache_types;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        RESP,
        DONE
    } adapter_state_t;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BURST_LEN = LINE_BITS / BEAT_BITS;

endpackage

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - cache dfp line request to 4-beat bmem burst converter
// Optional CACHELINE_ADAPTER_RADDR_CHECK_EN: drop read beats whose bmem_raddr does not match the burst base.
module cacheline_adapter
    import cache_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = LINE_BITS,
    parameter int BEAT_WIDTH = BEAT_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_BITS    = $clog2(LINE_WIDTH / BEAT_WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(LINE_WIDTH / BEAT_WIDTH - 1);

    adapter_state_t        state;
    adapter_state_t        state_next;
    logic [CNT_BITS-1:0]   beat_cnt;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  raddr_ok;
    logic                  rd_beat;
    logic                  wr_beat;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    logic unused_bits;
    assign unused_bits = ^dfp_addr[OFFSET_BITS-1:0];
    assign raddr_ok    = (bmem_raddr == base_addr);

    always_ff @(posedge clk) begin
        if (!rst && state == RD_DATA && bmem_rvalid) begin
            assert (raddr_ok)
            else $error("cacheline_adapter: dropped read beat, raddr %h base %h", bmem_raddr, base_addr);
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{bmem_raddr, dfp_addr[OFFSET_BITS-1:0]};
    assign raddr_ok    = 1'b1;
`endif

    assign rd_beat    = (state == RD_DATA) && bmem_rvalid && raddr_ok;
    assign wr_beat    = (state == WR_BURST) && bmem_ready;
    assign bmem_addr  = base_addr;
    assign bmem_wdata = line_buf[int'(beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH];
    assign dfp_rdata  = line_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dfp_resp   = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_next = WR_BURST;
                end else if (dfp_read) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rd_beat && beat_cnt == LAST_BEAT) begin
                    state_next = RESP;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                if (wr_beat && beat_cnt == LAST_BEAT) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                dfp_resp   = 1'b1;
                state_next = DONE;
            end
            // DONE deliberately ignores a still-held request so it cannot retrigger
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            beat_cnt <= '0;
        end else if (rd_beat || wr_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Line buffer and base are not reset; a request reloads them before use
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            base_addr <= {dfp_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            if (dfp_write) begin
                line_buf <= dfp_wdata;
            end
        end else if (rd_beat) begin
            line_buf[int'(beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - self-checking bench for cacheline_adapter with a burst memory model
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_write;
        bit           both;
        logic [31:0]  addr;
        logic [255:0] line;
        int           rd_stall;
        int           gap_beat;
        int           gap_len;
        int           wr_stall_beat;
        int           wr_stall_len;
        int           hold;
        logic [31:0]  exp_base;
        int           exp_lat;
    } vec_t;

    typedef struct {
        bit           is_write;
        logic [255:0] line;
    } scb_t;

    int checks = 0;
    int failures = 0;

    scb_t        exp_q[$];
    logic [63:0] wq[$];

    int           cyc = 0;
    int           resp_count = 0;
    int           resp_cyc = 0;
    int           rd_cmds = 0;
    int           rd_cmd_cyc = -1;
    logic [31:0]  rd_base = '0;
    logic [31:0]  wr_addr = '0;
    logic [255:0] mem_line = '0;
    bit           rd_arm = 0;
    bit           rd_active = 0;
    bit           rd_pause = 0;
    int           beat_idx = 0;
    int           rd_stall_left = 0;
    int           gap_beat = -1;
    int           gap_left = 0;
    int           bad_beat = -1;
    int           bad_left = 0;
    int           wr_beats = 0;
    int           wr_stall_beat = -1;
    int           wr_stall_left = 0;
    int           first_wr_cyc = -1;

    task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // One clock of the memory model: observe outputs at negedge, drive inputs for the next posedge
    task automatic step();
        scb_t e;
        @(negedge clk);
        cyc++;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        if (dfp_resp) begin
            resp_count++;
            resp_cyc = cyc;
            check_int("resp_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.is_write) check_line("dfp_rdata", dfp_rdata, e.line);
            end
        end
        if (rd_arm) begin
            rd_active = 1;
            rd_arm    = 0;
        end
        if (bmem_read) begin
            rd_cmds++;
            if (rd_stall_left > 0) begin
                rd_stall_left--;
            end else begin
                bmem_ready = 1'b1;
                rd_arm     = 1;
                rd_cmd_cyc = cyc;
                rd_base    = bmem_addr;
            end
        end else if (rd_active && beat_idx < 4 && !rd_pause) begin
            if (beat_idx == gap_beat && gap_left > 0) begin
                gap_left--;
            end else if (beat_idx == bad_beat && bad_left > 0) begin
                bad_left--;
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'hDEAD_0000;
                bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = rd_base;
                bmem_rdata  = mem_line[64*beat_idx +: 64];
                beat_idx++;
            end
        end
        if (bmem_write) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            wr_addr = bmem_addr;
            check_int("wr_beat_expected", (wq.size() > 0) ? 1 : 0, 1);
            if (wq.size() > 0) begin
                check_line("bmem_wdata", {192'b0, bmem_wdata}, {192'b0, wq[0]});
                if (wr_beats == wr_stall_beat && wr_stall_left > 0) begin
                    wr_stall_left--;
                end else begin
                    bmem_ready = 1'b1;
                    void'(wq.pop_front());
                    wr_beats++;
                end
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   n;
        int   resp0;
        int   cmds0;
        scb_t e;
        mem_line      = v.line;
        rd_arm        = 0;
        rd_active     = 0;
        beat_idx      = 0;
        rd_stall_left = v.rd_stall;
        gap_beat      = v.gap_beat;
        gap_left      = v.gap_len;
        wr_beats      = 0;
        wr_stall_beat = v.wr_stall_beat;
        wr_stall_left = v.wr_stall_len;
        first_wr_cyc  = -1;
        rd_cmd_cyc    = -1;
        e.is_write    = v.is_write;
        e.line        = v.line;
        exp_q.push_back(e);
        if (v.is_write) begin
            for (int i = 0; i < 4; i++) wq.push_back(v.line[64*i +: 64]);
        end
        resp0     = resp_count;
        cmds0     = rd_cmds;
        dfp_addr  = v.addr;
        dfp_wdata = v.is_write ? v.line : ~v.line;
        dfp_write = v.is_write;
        dfp_read  = !v.is_write || v.both;
        n = 0;
        while (resp_count == resp0 && n < 100) begin
            step();
            n++;
        end
        for (int i = 0; i < v.hold; i++) step();
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        step();
        step();
        check_int({tag, "_resp_count"}, resp_count - resp0, 1);
        check_int({tag, "_scb_drained"}, exp_q.size(), 0);
        if (v.is_write) begin
            check_int({tag, "_wr_latency"}, resp_cyc - first_wr_cyc, v.exp_lat);
            check_line({tag, "_wr_addr"}, {224'b0, wr_addr}, {224'b0, v.exp_base});
            check_int({tag, "_wr_beats"}, wr_beats, 4);
            check_int({tag, "_rd_cmds"}, rd_cmds - cmds0, 0);
        end else begin
            check_int({tag, "_rd_latency"}, resp_cyc - rd_cmd_cyc, v.exp_lat);
            check_line({tag, "_rd_addr"}, {224'b0, rd_base}, {224'b0, v.exp_base});
            check_int({tag, "_rd_cmd_cycles"}, rd_cmds - cmds0, v.rd_stall + 1);
        end
        exp_q.delete();
        wq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   n;
        int   resp0;
        int   cmds0;

        vecs[0] = '{0, 0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    0, -1, 0, -1, 0, 0, 32'h0000_1220, 5};
        vecs[1] = '{1, 0, 32'h0000_0040,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    0, -1, 0, 2, 2, 0, 32'h0000_0040, 6};
        vecs[2] = '{0, 0, 32'h0000_0080,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
                    0, -1, 0, -1, 0, 2, 32'h0000_0080, 5};
        vecs[3] = '{0, 0, 32'hFFFF_FFFF,
                    {64'hCAFE_BABE_0000_0003, 64'hCAFE_BABE_0000_0002,
                     64'hCAFE_BABE_0000_0001, 64'hCAFE_BABE_0000_0000},
                    3, 1, 2, -1, 0, 0, 32'hFFFF_FFE0, 7};
        vecs[4] = '{1, 0, 32'h1000_001F,
                    {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                     64'h5555_5555_5555_5555, 64'hA5A5_A5A5_5A5A_5A5A},
                    0, -1, 0, -1, 0, 0, 32'h1000_0000, 4};
        vecs[5] = '{1, 1, 32'h0000_2468,
                    {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                     64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                    0, -1, 0, 0, 1, 0, 32'h0000_2460, 5};

        rst         = 1'b1;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        step();
        step();
        check_int("reset_dfp_resp", int'(dfp_resp), 0);
        check_int("reset_bmem_read", int'(bmem_read), 0);
        check_int("reset_bmem_write", int'(bmem_write), 0);
        rst = 1'b0;
        step();
        check_int("idle_bmem_read", int'(bmem_read), 0);
        check_int("idle_bmem_write", int'(bmem_write), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset lands after two read beats; the remaining two arrive while idle
        mem_line      = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                         64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        rd_arm        = 0;
        rd_active     = 0;
        beat_idx      = 0;
        rd_stall_left = 0;
        gap_beat      = -1;
        gap_left      = 0;
        resp0         = resp_count;
        dfp_addr      = 32'h0000_3000;
        dfp_read      = 1'b1;
        n = 0;
        while (beat_idx < 2 && n < 50) begin
            step();
            n++;
        end
        check_int("rst_mid_reached_beat2", beat_idx, 2);
        rst      = 1'b1;
        dfp_read = 1'b0;
        rd_pause = 1;
        step();
        rst      = 1'b0;
        rd_pause = 0;
        cmds0    = rd_cmds;
        for (int i = 0; i < 5; i++) step();
        check_int("rst_mid_no_resp", resp_count - resp0, 0);
        check_int("rst_mid_no_new_cmd", rd_cmds - cmds0, 0);
        v = '{0, 0, 32'h0000_3010,
              {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
               64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001},
              0, -1, 0, -1, 0, 0, 32'h0000_3000, 5};
        run_vec("after_rst", v);

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        bad_beat = 2;
        bad_left = 1;
        v = '{0, 0, 32'h0000_4000,
              {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
               64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001},
              0, -1, 0, -1, 0, 0, 32'h0000_4000, 6};
        run_vec("raddr_drop", v);
        bad_beat = -1;
        bad_left = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
